// File: rtl/fpu_64_if.sv
// Operand/result bundle for the fpu_64 double-precision execution unit.
// The master drives operands; the slave (fpu_64) drives result and flags.
interface fpu_64_if;
   logic [1:0]  rmode;
   logic [2:0]  fpu_op;
   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] out;
   logic        inf;
   logic        snan;
   logic        qnan;
   logic        ine;
   logic        overflow;
   logic        underflow;
   logic        zero;
   logic        div_by_zero;

   modport master (output rmode, fpu_op, a, b,
                   input  out, inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero);
   modport slave  (input  rmode, fpu_op, a, b,
                   output out, inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero);
endinterface

// File: rtl/fpu_64.sv
// Two-stage IEEE-754 double add/sub/mul/div: operands registered, then result and flags.
// Subnormal inputs read as zero and tiny results flush to zero, so no subnormal is ever produced.
module fpu_64 (
   input  logic    clk,
   input  logic    rst,
   fpu_64_if.slave bus
);
   localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

   logic [63:0]  r_a, r_b, r_out;
   logic [2:0]   r_op;
   logic [1:0]   r_rmode;
   logic         r_inf, r_snan, r_qnan, r_ine, r_ovf, r_unf, r_zero, r_dbz;

   logic         w_sa, w_sb, w_sb_add, w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_snan;
   logic [10:0]  w_ea, w_eb, w_el, w_esm, w_d;
   logic [52:0]  w_ma, w_mb, w_ml, w_msm;
   logic         w_sl, w_ss, w_stk;
   logic [55:0]  w_x, w_al, w_aln, w_diff, w_m;
   logic [56:0]  w_sum;
   logic [5:0]   w_lz;
   logic [105:0] w_p;
   logic [110:0] w_num, w_den, w_q, w_rem;
   logic         w_qtop, w_dstk;
   logic signed [12:0] w_e, w_er;
   logic         w_rs, w_zres, w_spec, w_dbz, w_inc, w_away, w_ine, w_ovf, w_unf;
   logic [63:0]  w_spec_out, w_out;
   logic [53:0]  w_sig;
   logic [51:0]  w_frac;

   function automatic logic [5:0] lzc56(input logic [55:0] v);
      logic [5:0] n;
      n = 6'd0;
      for (int i = 0; i < 56; i++)
         if (v[i]) n = 6'(55 - i);
      return n;
   endfunction

   assign w_sa     = r_a[63];
   assign w_sb     = r_b[63];
   assign w_sb_add = w_sb ^ (r_op == 3'd1);
   assign w_ea     = r_a[62:52];
   assign w_eb     = r_b[62:52];
   assign w_za     = (w_ea == 11'd0);
   assign w_zb     = (w_eb == 11'd0);
   assign w_ia     = (&w_ea) & ~(|r_a[51:0]);
   assign w_ib     = (&w_eb) & ~(|r_b[51:0]);
   assign w_na     = (&w_ea) & (|r_a[51:0]);
   assign w_nb     = (&w_eb) & (|r_b[51:0]);
   assign w_snan   = (w_na & ~r_a[51]) | (w_nb & ~r_b[51]);
   assign w_ma     = w_za ? 53'd0 : {1'b1, r_a[51:0]};
   assign w_mb     = w_zb ? 53'd0 : {1'b1, r_b[51:0]};

   // Significand product and a 59-bit quotient (value q / 2^58) with remainder as sticky
   assign w_p      = {53'd0, w_ma} * {53'd0, w_mb};
   assign w_num    = {w_ma, 58'd0};
   assign w_den    = {58'd0, (w_zb ? 53'd1 : w_mb)};
   assign w_q      = w_num / w_den;
   assign w_rem    = w_num % w_den;
   assign w_qtop   = |w_q[110:58];
   assign w_dstk   = |w_rem;

   always_comb begin
      if ({w_eb, w_mb} > {w_ea, w_ma}) begin
         w_sl = w_sb_add; w_el = w_eb; w_ml = w_mb;
         w_ss = w_sa;     w_esm = w_ea; w_msm = w_ma;
      end else begin
         w_sl = w_sa;     w_el = w_ea; w_ml = w_ma;
         w_ss = w_sb_add; w_esm = w_eb; w_msm = w_mb;
      end
      w_d = w_el - w_esm;
      w_x = {w_msm, 3'b000};
      if (w_d >= 11'd56) begin
         w_al  = 56'd0;
         w_stk = |w_msm;
      end else begin
         w_al  = w_x >> w_d;
         w_stk = |(w_x << (7'd56 - w_d[6:0]));
      end
      w_aln  = {w_al[55:1], w_al[0] | w_stk};
      w_sum  = {1'b0, w_ml, 3'b000} + {1'b0, w_aln};
      w_diff = {w_ml, 3'b000} - w_aln;
      w_lz   = lzc56(w_diff);
   end

   always_comb begin
      w_m = 56'd0; w_e = 13'sd0; w_rs = 1'b0; w_zres = 1'b0;
      w_spec = 1'b0; w_spec_out = 64'd0; w_dbz = 1'b0;
      case (r_op)
         3'd0, 3'd1: begin
            w_rs = w_sl;
            if (w_sl == w_ss) begin
               w_m    = w_sum[56] ? {w_sum[56:2], w_sum[1] | w_sum[0]} : w_sum[55:0];
               w_e    = $signed({2'b00, w_el}) + (w_sum[56] ? 13'sd1 : 13'sd0);
               w_zres = (w_sum == 57'd0);
            end else begin
               w_m    = w_diff << w_lz;
               w_e    = $signed({2'b00, w_el}) - $signed({7'd0, w_lz});
               w_zres = (w_diff == 56'd0);
               if (w_diff == 56'd0) w_rs = (r_rmode == 2'b11);
            end
            if (w_ia & w_ib & (w_sa != w_sb_add)) begin
               w_spec = 1'b1; w_spec_out = QNAN;
            end else if (w_ia | w_ib) begin
               w_spec = 1'b1; w_spec_out = {(w_ia ? w_sa : w_sb_add), 11'h7FF, 52'd0};
            end
         end
         3'd2: begin
            w_rs = w_sa ^ w_sb;
            w_m  = w_p[105] ? {w_p[105:51], |w_p[50:0]} : {w_p[104:50], |w_p[49:0]};
            w_e  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 13'sd1023
                   + (w_p[105] ? 13'sd1 : 13'sd0);
            if ((w_ia | w_ib) & (w_za | w_zb)) begin
               w_spec = 1'b1; w_spec_out = QNAN;
            end else if (w_ia | w_ib) begin
               w_spec = 1'b1; w_spec_out = {w_rs, 11'h7FF, 52'd0};
            end else if (w_za | w_zb) begin
               w_zres = 1'b1;
            end
         end
         3'd3: begin
            w_rs = w_sa ^ w_sb;
            w_m  = w_qtop ? {w_q[58:4], (|w_q[3:0]) | w_dstk} : {w_q[57:3], (|w_q[2:0]) | w_dstk};
            w_e  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb})
                   + (w_qtop ? 13'sd1023 : 13'sd1022);
            if ((w_za & w_zb) | (w_ia & w_ib)) begin
               w_spec = 1'b1; w_spec_out = QNAN;
            end else if (w_ia) begin
               w_spec = 1'b1; w_spec_out = {w_rs, 11'h7FF, 52'd0};
            end else if (w_ib) begin
               w_zres = 1'b1;
            end else if (w_zb) begin
               w_spec = 1'b1; w_spec_out = {w_rs, 11'h7FF, 52'd0}; w_dbz = 1'b1;
            end else if (w_za) begin
               w_zres = 1'b1;
            end
         end
         default: ;
      endcase
      // NaN operands and reserved opcodes override every other outcome
      if (w_na | w_nb | (r_op > 3'd3)) begin
         w_spec = 1'b1; w_spec_out = QNAN; w_dbz = 1'b0;
      end
   end

   always_comb begin
      case (r_rmode)
         2'b00:   w_inc = w_m[2] & (w_m[3] | (|w_m[1:0]));
         2'b10:   w_inc = ~w_rs & (|w_m[2:0]);
         2'b11:   w_inc = w_rs & (|w_m[2:0]);
         default: w_inc = 1'b0;
      endcase
      w_sig  = {1'b0, w_m[55:3]} + {53'd0, w_inc};
      w_er   = w_sig[53] ? w_e + 13'sd1 : w_e;
      w_frac = w_sig[53] ? w_sig[52:1] : w_sig[51:0];
      w_away = (r_rmode == 2'b00) | ((r_rmode == 2'b10) & ~w_rs) | ((r_rmode == 2'b11) & w_rs);
      w_out  = {w_rs, w_er[10:0], w_frac};
      w_ine  = |w_m[2:0];
      w_ovf  = 1'b0;
      w_unf  = 1'b0;
      if (w_spec) begin
         w_out = w_spec_out; w_ine = 1'b0;
      end else if (w_zres) begin
         w_out = {w_rs, 63'd0}; w_ine = 1'b0;
      end else if (w_e <= 13'sd0) begin
         w_out = {w_rs, 63'd0}; w_unf = 1'b1; w_ine = 1'b1;
      end else if (w_er >= 13'sd2047) begin
         w_ovf = 1'b1; w_ine = 1'b1;
         w_out = w_away ? {w_rs, 11'h7FF, 52'd0} : {w_rs, 11'h7FE, {52{1'b1}}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a <= 64'd0; r_b <= 64'd0; r_op <= 3'd0; r_rmode <= 2'd0;
         r_out <= 64'd0; r_inf <= 1'b0; r_snan <= 1'b0; r_qnan <= 1'b0;
         r_ine <= 1'b0; r_ovf <= 1'b0; r_unf <= 1'b0; r_zero <= 1'b0; r_dbz <= 1'b0;
      end else begin
         r_a <= bus.a; r_b <= bus.b; r_op <= bus.fpu_op; r_rmode <= bus.rmode;
         r_out  <= w_out;
         r_inf  <= (&w_out[62:52]) & ~(|w_out[51:0]);
         r_qnan <= (&w_out[62:52]) & w_out[51];
         r_zero <= ~(|w_out[62:0]);
         r_snan <= w_snan;
         r_ine  <= w_ine;
         r_ovf  <= w_ovf;
         r_unf  <= w_unf;
         r_dbz  <= w_dbz;
      end
   end

   assign bus.out         = r_out;
   assign bus.inf         = r_inf;
   assign bus.snan        = r_snan;
   assign bus.qnan        = r_qnan;
   assign bus.ine         = r_ine;
   assign bus.overflow    = r_ovf;
   assign bus.underflow   = r_unf;
   assign bus.zero        = r_zero;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_fpu_64.sv
// Directed vectors, a pipelined random stream checked against real arithmetic, and async reset.
module tb_fpu_64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fpu_64_if bus();
   fpu_64 dut (.clk(clk), .rst(rst), .bus(bus));

   localparam logic [7:0] F_INF = 8'h80, F_SNAN = 8'h40, F_QNAN = 8'h20, F_INE = 8'h10;
   localparam logic [7:0] F_OVF = 8'h08, F_UNF = 8'h04, F_ZERO = 8'h02, F_DBZ = 8'h01;
   localparam logic [63:0] ONE = 64'h3FF0_0000_0000_0000, QN = 64'h7FF8_0000_0000_0000;
   localparam logic [63:0] PINF = 64'h7FF0_0000_0000_0000, MAXF = 64'h7FEF_FFFF_FFFF_FFFF;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  op;
      logic [1:0]  rm;
      logic [63:0] eo;
      logic [7:0]  ef;
   } vec_t;

   vec_t tbl[$];
   vec_t rv[100];
   int   n_cmp = 0;
   int   n_fail = 0;
   logic [7:0] got_f;

   assign got_f = {bus.inf, bus.snan, bus.qnan, bus.ine,
                   bus.overflow, bus.underflow, bus.zero, bus.div_by_zero};

   function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                               input logic [1:0] rm, input logic [63:0] eo, input logic [7:0] ef);
      vec_t v;
      v.a = a; v.b = b; v.op = op; v.rm = rm; v.eo = eo; v.ef = ef;
      return v;
   endfunction

   function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op);
      real ra, rb, rr;
      ra = $bitstoreal(a);
      rb = $bitstoreal(b);
      case (op)
         3'd0:    rr = ra + rb;
         3'd1:    rr = ra - rb;
         3'd2:    rr = ra * rb;
         default: rr = ra / rb;
      endcase
      return $realtobits(rr);
   endfunction

   function automatic logic [63:0] rnd_norm();
      logic        s;
      logic [10:0] e;
      logic [51:0] f;
      s = 1'($urandom_range(0, 1));
      e = 11'($urandom_range(823, 1223));
      f = {20'($urandom), 32'($urandom)};
      return {s, e, f};
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, got, expv);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.a = v.a; bus.b = v.b; bus.fpu_op = v.op; bus.rmode = v.rm;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl.push_back(mk(ONE, ONE, 3'd0, 2'b00, 64'h4000_0000_0000_0000, 8'h00));
      tbl.push_back(mk(ONE, ONE, 3'd1, 2'b00, 64'h0000_0000_0000_0000, F_ZERO));
      tbl.push_back(mk(ONE, ONE, 3'd1, 2'b11, 64'h8000_0000_0000_0000, F_ZERO));
      tbl.push_back(mk(64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd2, 2'b00,
                       64'h4008_0000_0000_0000, 8'h00));
      tbl.push_back(mk(ONE, 64'h4008_0000_0000_0000, 3'd3, 2'b00, 64'h3FD5_5555_5555_5555, F_INE));
      tbl.push_back(mk(ONE, 64'd0, 3'd3, 2'b00, PINF, F_INF | F_DBZ));
      tbl.push_back(mk(64'd0, 64'd0, 3'd3, 2'b00, QN, F_QNAN));
      tbl.push_back(mk(64'h7FF0_0000_0000_0001, ONE, 3'd0, 2'b00, QN, F_SNAN | F_QNAN));
      tbl.push_back(mk(MAXF, 64'h4000_0000_0000_0000, 3'd2, 2'b00, PINF, F_INF | F_OVF | F_INE));
      tbl.push_back(mk(MAXF, 64'h4000_0000_0000_0000, 3'd2, 2'b01, MAXF, F_OVF | F_INE));
      tbl.push_back(mk(MAXF, 64'h4000_0000_0000_0000, 3'd2, 2'b10, PINF, F_INF | F_OVF | F_INE));
      tbl.push_back(mk(MAXF, 64'h4000_0000_0000_0000, 3'd2, 2'b11, MAXF, F_OVF | F_INE));
      tbl.push_back(mk(64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 3'd2, 2'b00,
                       64'd0, F_UNF | F_INE | F_ZERO));
      tbl.push_back(mk(PINF, PINF, 3'd1, 2'b00, QN, F_QNAN));
      tbl.push_back(mk(64'd0, PINF, 3'd2, 2'b00, QN, F_QNAN));
      tbl.push_back(mk(ONE, ONE, 3'd5, 2'b00, QN, F_QNAN));
      tbl.push_back(mk(ONE, PINF, 3'd3, 2'b00, 64'd0, F_ZERO));
      tbl.push_back(mk(64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd2, 2'b00,
                       64'hC018_0000_0000_0000, 8'h00));
      tbl.push_back(mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'd0, 2'b00,
                       64'h8000_0000_0000_0000, F_ZERO));
      tbl.push_back(mk(ONE, 64'h3CA0_0000_0000_0000, 3'd0, 2'b00, ONE, F_INE));
      tbl.push_back(mk(ONE, 64'h3CA0_0000_0000_0000, 3'd0, 2'b10, 64'h3FF0_0000_0000_0001, F_INE));
      tbl.push_back(mk(64'h0000_0000_0000_0001, ONE, 3'd0, 2'b00, ONE, 8'h00));
      tbl.push_back(mk(ONE, 64'h3CA0_0000_0000_0000, 3'd1, 2'b00, 64'h3FEF_FFFF_FFFF_FFFF, 8'h00));

      for (int i = 0; i < 100; i++) begin
         rv[i].a  = rnd_norm();
         rv[i].b  = rnd_norm();
         rv[i].op = 3'($urandom_range(0, 3));
         rv[i].rm = 2'b00;
         rv[i].eo = ref_op(rv[i].a, rv[i].b, rv[i].op);
         rv[i].ef = 8'h00;
      end

      drive(tbl[0]);
      #1;
      check("reset_out", bus.out, 64'd0);
      check("reset_flags", 64'(got_f), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         @(negedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_out", i), bus.out, tbl[i].eo);
         check($sformatf("vec%0d_flags", i), 64'(got_f), 64'(tbl[i].ef));
      end

      for (int j = 0; j < 102; j++) begin
         @(negedge clk);
         if (j >= 2) begin
            check($sformatf("rand%0d_out", j - 2), bus.out, rv[j - 2].eo);
            check($sformatf("rand%0d_zero", j - 2), 64'(bus.zero),
                  64'(rv[j - 2].eo[62:0] == 63'd0));
         end
         if (j < 100) drive(rv[j]);
      end

      @(negedge clk);
      drive(tbl[0]);
      @(negedge clk);
      drive(tbl[3]);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_out", bus.out, 64'd0);
      check("midrst_flags", 64'(got_f), 64'd0);
      @(negedge clk);
      check("rst_hold_out", bus.out, 64'd0);
      check("rst_hold_flags", 64'(got_f), 64'd0);
      rst = 1'b0;
      drive(tbl[17]);
      @(negedge clk);
      @(negedge clk);
      check("post_rst_out", bus.out, tbl[17].eo);
      check("post_rst_flags", 64'(got_f), 64'(tbl[17].ef));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
